// File: rtl/uart_rx_ctrl.sv
// UART receive controller: detects the start bit, times the bit centres and
// pulses shift_en into an external 10-bit shift register. Once the frame is
// complete, it captures the byte and presents it with a valid/ready handshake
// plus sticky frame_err/overrun flags.
// Build option: define UART_RX_SYNC_EN to pass rx through a two-flop
// synchronizer. This adds 2 cycles of latency relative to rx.
module uart_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [9:0] frame,
    output logic       shift_en,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t      state_q;
    logic [15:0] baud_cnt_q;
    logic [3:0]  bit_cnt_q;
    logic        shift_en_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        frame_err_q;
    logic        overrun_q;
    logic        armed_q;      // cleared after a bad stop bit until the line returns high
    logic        rx_s;
    logic        accept;
    logic        frame_err_d;
    logic        overrun_d;
    logic        unused_start_bit;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer; it resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end
    assign rx_s = sync_q[1];
`else
    assign rx_s = rx;
`endif

    // The start bit is not checked; the start-bit centre is checked against rx_s instead.
    assign unused_start_bit = frame[0];

    assign accept = valid_q & ready;
    // A new DONE on the same edge as an accept replaces the sticky flags.
    // Otherwise the flags accumulate.
    assign frame_err_d = (frame_err_q & ~accept) | ~frame[9];
    assign overrun_d   = (overrun_q & ~accept) | (valid_q & ~ready);

    // Receive FSM: bit timing, shift pulses, byte capture and handshake state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_en_q  <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            shift_en_q <= 1'b0;
            if (accept) begin
                valid_q     <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    baud_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    if (!armed_q) begin
                        if (rx_s) begin
                            armed_q <= 1'b1;
                        end
                    end else if (!rx_s) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_cnt_q == HALF_LAST) begin
                        baud_cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
                        end else begin
                            shift_en_q <= 1'b1;
                            bit_cnt_q  <= 4'd1;
                            state_q    <= DATA;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt_q == FULL_LAST) begin
                        shift_en_q <= 1'b1;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd8) begin
                            state_q <= STOP;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    // bit_cnt_q == 10 means the stop pulse is in flight this cycle.
                    // Leave STOP only after the register has taken it, so frame is complete in DONE.
                    if (bit_cnt_q == 4'd10) begin
                        baud_cnt_q <= '0;
                        state_q    <= DONE;
                    end else if (baud_cnt_q == FULL_LAST) begin
                        shift_en_q <= 1'b1;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= 4'd10;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    data_q      <= frame[8:1];
                    valid_q     <= 1'b1;
                    frame_err_q <= frame_err_d;
                    overrun_q   <= overrun_d;
                    armed_q     <= frame[9];
                    bit_cnt_q   <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign shift_en  = shift_en_q;
    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl with CLKS_PER_BIT = 16 and a model of the downstream
// shift register. Stimulus pushes the expected byte and flags into a queue.
// A negedge monitor pops one entry each time the controller presents a new byte.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int CPB = 16;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [9:0] frame = '0;
    logic       shift_en;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   fall_cyc = 0;
    int   valid_rise_cyc = -1;
    int   valid_hi_cnt = 0;
    exp_t exp_q[$];
    int   pulse_q[$];

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .frame     (frame),
        .shift_en  (shift_en),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter and the downstream shift register: rx enters bit 9 and shifts toward bit 0.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (shift_en) begin
            frame <= {rx, frame[9:1]};
        end
    end

    // Monitor: records shift pulses and valid activity, and scores each new byte presentation.
    initial begin
        logic prev_valid;
        logic prev_busy;
        exp_t e;
        prev_valid = 1'b0;
        prev_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (shift_en) pulse_q.push_back(cyc);
            if (valid) valid_hi_cnt++;
            if (valid && !prev_valid) valid_rise_cyc = cyc;
            if (valid && (!prev_valid || (prev_busy && !busy))) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_byte: got data=%h fe=%b ov=%b, required no output",
                             data, frame_err, overrun);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e.d || frame_err !== e.fe || overrun !== e.ov) begin
                        n_err++;
                        $display("FAIL byte_txn: got data=%h fe=%b ov=%b, required data=%h fe=%b ov=%b",
                                 data, frame_err, overrun, e.d, e.fe, e.ov);
                    end else begin
                        $display("txn  byte data=%h fe=%b ov=%b", data, frame_err, overrun);
                    end
                end
            end
            prev_valid = valid;
            prev_busy  = busy;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("chk  %s = %0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic ov);
        exp_t e;
        e.d  = d;
        e.fe = fe;
        e.ov = ov;
        return e;
    endfunction

    // Drives the first nbits of a frame (bit 0 first), one bit period each.
    task automatic send_bits(input logic [9:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            if (i == 0) fall_cyc = cyc + 1;
            tick(CPB);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits({1'b1, b, 1'b0}, 10);
        rx = 1'b1;
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid, 0);
        check("rst_data", data, 8'h00);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_shift_en", shift_en, 0);
        rst = 1'b0;
        tick(4);

        // Clean 0x55 frame: pulse count, position, spacing and valid latency
        pulse_q.delete();
        exp_q.push_back(mk(8'h55, 1'b0, 1'b0));
        send_byte(8'h55);
        check("p55_count", pulse_q.size(), 10);
        if (pulse_q.size() == 10) begin
            check("p55_first_offset", pulse_q[0] - fall_cyc, 8 + SYNC_LAT);
            bad = 0;
            for (int i = 1; i < 10; i++) begin
                if (pulse_q[i] - pulse_q[i-1] != CPB) bad++;
            end
            check("p55_spacing_errors", bad, 0);
            check("p55_valid_latency", valid_rise_cyc - pulse_q[9], 2);
        end
        check("p55_data", data, 8'h55);
        check("p55_valid", valid, 1);
        check("p55_frame_err", frame_err, 0);
        pulse_ready();
        check("p55_valid_after_ready", valid, 0);

        // Glitch: rx low for 4 cycles only
        pulse_q.delete();
        rx = 1'b0;
        tick(4);
        check("glitch_busy_high", busy, 1);
        rx = 1'b1;
        tick(5 + SYNC_LAT);
        check("glitch_busy_low", busy, 0);
        tick(10);
        check("glitch_pulses", pulse_q.size(), 0);

        // 0xA3 with stop bit 0, then the line stays low (break)
        pulse_q.delete();
        exp_q.push_back(mk(8'hA3, 1'b1, 1'b0));
        send_bits({1'b0, 8'hA3, 1'b0}, 10);
        check("pA3_data", data, 8'hA3);
        check("pA3_valid", valid, 1);
        check("pA3_frame_err", frame_err, 1);
        check("pA3_pulses", pulse_q.size(), 10);
        pulse_q.delete();
        tick(40);
        check("break_busy", busy, 0);
        check("break_pulses", pulse_q.size(), 0);
        rx = 1'b1;
        tick(4);
        pulse_ready();
        check("pA3_valid_cleared", valid, 0);
        check("pA3_frame_err_cleared", frame_err, 0);

        // Overrun: ready held low across 0x11 and 0x22
        exp_q.push_back(mk(8'h11, 1'b0, 1'b0));
        exp_q.push_back(mk(8'h22, 1'b0, 1'b1));
        send_byte(8'h11);
        send_byte(8'h22);
        check("ovr_data", data, 8'h22);
        check("ovr_overrun", overrun, 1);
        check("ovr_valid", valid, 1);
        pulse_ready();
        check("ovr_valid_cleared", valid, 0);
        check("ovr_overrun_cleared", overrun, 0);
        check("ovr_frame_err_cleared", frame_err, 0);

        // Back-to-back 0xFF and 0x00 with ready high throughout
        valid_hi_cnt = 0;
        ready = 1'b1;
        exp_q.push_back(mk(8'hFF, 1'b0, 1'b0));
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0));
        send_byte(8'hFF);
        send_byte(8'h00);
        tick(2);
        check("b2b_valid_cycles", valid_hi_cnt, 2);
        check("b2b_overrun", overrun, 0);
        ready = 1'b0;

        // Reset during bit 4 of a frame while a flagged byte is pending
        exp_q.push_back(mk(8'h5A, 1'b1, 1'b0));
        send_bits({1'b0, 8'h5A, 1'b0}, 10);
        rx = 1'b1;
        tick(4);
        send_bits({1'b1, 8'h3C, 1'b0}, 5);
        tick(8);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_shift_en", shift_en, 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick(20);
        pulse_q.delete();
        exp_q.push_back(mk(8'h3C, 1'b0, 1'b0));
        send_byte(8'h3C);
        check("p3C_data", data, 8'h3C);
        check("p3C_valid", valid, 1);
        check("p3C_frame_err", frame_err, 0);
        check("p3C_pulses", pulse_q.size(), 10);

        tick(5);
        check("scoreboard_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, meaning clock cycles per UART bit (100 MHz / 9600 baud), legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx  input  1  serial line, idle high.
REQ-005 SHALL have port frame  input  10  parallel output of the downstream 10-bit Rx shift register; bit 0 = start, bits 8:1 = data LSB-first, bit 9 = stop.
REQ-006 SHALL have port shift_en  output  1  one-cycle enable to the shift register, which loads rx into bit 9 and shifts toward bit 0.
REQ-007 SHALL have port data  output  8  received byte.
REQ-008 SHALL have port valid  output  1  data holds an unconsumed byte.
REQ-009 SHALL have port ready  input  1  consumer accepts data when valid and ready are both high.
REQ-010 SHALL have port frame_err  output  1  sticky until next accepted byte: last frame had stop bit 0.
REQ-011 SHALL have port overrun  output  1  sticky until next accepted byte: a frame completed while valid was high.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, DONE with a 16-bit baud counter and a 4-bit bit counter.
REQ-014 IDLE: on rx_s == 0, SHALL go to START with baud counter cleared; rx_s is the line after the optional synchronizer (REQ-026).
REQ-015 START: when baud counter reaches CLKS_PER_BIT/2 - 1, SHALL go to IDLE without asserting shift_en if rx_s == 1 (glitch); if rx_s == 0, SHALL pulse shift_en, clear the counter, set bit counter to 1 and go to DATA.
REQ-016 DATA: each time baud counter reaches CLKS_PER_BIT - 1, SHALL pulse shift_en, clear the counter and increment bit counter; after the pulse that makes bit counter 9, SHALL go to STOP.
REQ-017 STOP: when baud counter reaches CLKS_PER_BIT - 1, SHALL pulse shift_en (10th and last pulse of the frame) and go to DONE.
REQ-018 DONE: lasts exactly one cycle, in which frame reflects all 10 shifts; at its end SHALL load data <= frame[8:1], set valid, set frame_err if frame[9] == 0, set overrun if valid was already high and not accepted that cycle, then go to IDLE.
REQ-019 shift_en SHALL be high for exactly 10 cycles per accepted frame and 1 cycle per pulse, and 0 for a glitch start.
REQ-020 Latency: valid SHALL rise one cycle after DONE, i.e. 2 cycles after the stop-bit shift_en pulse.
REQ-021 Handshake: valid SHALL clear on the cycle after valid && ready; frame_err and overrun SHALL clear on that same edge unless a new DONE occurs on it.
REQ-022 Simultaneous DONE and valid && ready: the new byte SHALL load, valid SHALL remain 1, and overrun SHALL not be set.
REQ-023 data SHALL hold its value while valid is high, except when overwritten by a DONE (overrun case).
REQ-024 A frame with stop bit 0 SHALL still deliver data with valid; IDLE SHALL not re-arm until rx_s returns to 1 (break-condition guard).

Reset
REQ-025 On rst high, SHALL immediately force state IDLE, counters 0, shift_en 0, data 8'h00, valid 0, frame_err 0, overrun 0, busy 0, synchronizer flops 1; a reset mid-frame SHALL abandon the frame with no valid pulse.

Configuration
REQ-026 Macro UART_RX_SYNC_EN defined: rx SHALL pass through a two-flop synchronizer and all timing SHALL be 2 cycles later relative to rx. Undefined: rx_s = rx directly with zero added latency.

Verification (CLKS_PER_BIT = 16, shift register attached)
REQ-027 Send 0x55 with stop 1 -> exactly 10 shift_en pulses at 16-cycle spacing, the first 8 cycles after the falling edge; then data = 0x55, valid = 1, frame_err = 0.
REQ-028 rx low for 4 cycles, then high -> return to IDLE, no shift_en, busy low after at most 9 cycles.
REQ-029 Send 0xA3 with stop bit 0 -> data = 0xA3, valid = 1, frame_err = 1; no new start accepted until rx is high.
REQ-030 Hold ready = 0 and send 0x11 then 0x22 -> data = 0x22, overrun = 1; pulse ready -> valid, overrun and frame_err all 0.
REQ-031 Assert rst at bit 4 of a frame -> all outputs at their reset values immediately; the following clean 0x3C frame is received correctly.
REQ-032 ready = 1 throughout back-to-back frames 0xFF and 0x00 -> each byte shows valid for one cycle, overrun = 0.
